dock_io_cycle: RTL
==================

Name: dock_io_cycle

Overview:
- Sequential bus-cycle controller directly downstream of the Dock window-match stage.
- Consumes win_valid/win_index/sel_slot/is_read for the current CPU I/O request (iorq_n low) and drives per-slot active-low chip selects.
- Waits for the selected slot's ready, handshakes completion back to the CPU, and raises a bus error on an unmapped access or a slot timeout.
- Keeps sticky error status for the Dock register file.

Parameters:
- NUM_SLOTS, 5, number of physical slots; sel_slot values >= NUM_SLOTS are unmapped.
- WIN_INDEX_W, 4, width of win_index.
- SETUP_CYC, 1, cycles chip select is held before slot ready is sampled; legal range 0..15.
- TIMEOUT_CYC, 255, maximum ACTIVE cycles waiting for slot ready; legal range 1..255.

Ports:
- clk  in  1  Dock system clock.
- rst_n  in  1  asynchronous active-low reset.
- iorq_n  in  1  CPU I/O request, active low, synchronous to clk.
- win_valid  in  1  a decode window matched.
- win_index  in  WIN_INDEX_W  matching window index.
- sel_slot  in  3  target slot of the matching window.
- is_read  in  1  1 = read cycle, 0 = write cycle.
- slot_ready_n  in  NUM_SLOTS  per-slot ready, active low.
- clr_err  in  1  single-cycle pulse; clears sticky error status.
- slot_cs_n  out  NUM_SLOTS  per-slot chip select, active low, registered.
- cyc_read  out  1  latched direction of the current cycle.
- cpu_ready  out  1  CPU may complete the cycle, registered.
- bus_err  out  1  current cycle ended in error; held until iorq_n rises.
- err_flag  out  1  sticky error flag.
- err_code  out  2  01 = unmapped, 10 = timeout, 00 = none.
- err_win  out  WIN_INDEX_W  win_index latched at the error; 0 for unmapped.

Behaviour:
- Reset (async, rst_n low) values:
  - state = IDLE; slot_cs_n all 1; cpu_ready 0; bus_err 0; cyc_read 0.
  - err_flag 0; err_code 00; err_win 0; counters 0.
  - Reset mid-cycle drops chip selects immediately, with no completion.
- All outputs are registered. Inputs are sampled only on rising clk.
- IDLE:
  - When iorq_n == 0, latch slot, win_index and is_read.
  - If win_valid == 1 and sel_slot < NUM_SLOTS: assert slot_cs_n[slot] = 0 from the next cycle, then go to SETUP (or to ACTIVE if SETUP_CYC == 0).
  - Otherwise go to ERR with code 01.
  - Latency: iorq_n low sampled at edge N gives cs low after edge N.
- SETUP:
  - Count SETUP_CYC cycles, then go to ACTIVE.
  - Slot ready is ignored in this state.
- ACTIVE:
  - Timeout counter starts at 0.
  - If slot_ready_n[slot] == 0: go to DONE.
  - Else if the counter == TIMEOUT_CYC-1: go to ERR with code 10.
  - Else increment the counter.
  - Ready and timeout in the same cycle: ready wins.
- DONE:
  - cpu_ready = 1 and cs stays asserted.
  - On iorq_n == 1: go to IDLE and deassert cs and cpu_ready next edge.
- ERR:
  - slot_cs_n all 1; cpu_ready = 1; bus_err = 1.
  - Set err_flag, err_code and err_win on entry.
  - On iorq_n == 1: go to IDLE and clear bus_err and cpu_ready.
- Abort: iorq_n == 1 in SETUP or ACTIVE goes to IDLE, deasserts cs next edge, and records no error.
- Exactly one slot_cs_n bit is low at any time, or none.
- Decode inputs are ignored outside IDLE; the latched values are used for the whole cycle.
- Back-to-back requests need at least one iorq_n-high cycle, so IDLE is always revisited.
- clr_err clears err_flag/err_code/err_win next edge. If clr_err coincides with a new error entry, the new error wins.
- A later error overwrites err_code/err_win (last error recorded).

Decomposition:
- Package dock_io_pkg holds:
  - state enum: IDLE, SETUP, ACTIVE, DONE, ERR.
  - err_code constants: ERR_NONE = 2'b00, ERR_UNMAPPED = 2'b01, ERR_TIMEOUT = 2'b10.
- One counter register is shared between SETUP and ACTIVE, sized 8 bits.
- No sub-module: a single FSM plus counter; the timeout counter is too small to warrant its own module.

Test Plan:
- Mapped read:
  - Stimulus: iorq_n low, win_valid = 1, sel_slot = 2, is_read = 1, SETUP_CYC = 1, slot_ready_n[2] low 3 cycles after cs.
  - Required: slot_cs_n = 5'b11011 one edge after iorq_n low; cpu_ready high the edge after ready; cs released one edge after iorq_n high; err_flag stays 0.
- Unmapped:
  - Stimulus: win_valid = 0 with iorq_n low.
  - Required: no cs asserted; bus_err = 1 and cpu_ready = 1 next edge; err_code = 01, err_win = 0; bus_err clears after iorq_n high.
- Slot out of range:
  - Stimulus: win_valid = 1, sel_slot = 6, NUM_SLOTS = 5, win_index = 9.
  - Required: error path, err_code = 01, err_win = 0; slot_cs_n stays all 1.
- Timeout:
  - Stimulus: TIMEOUT_CYC = 4, sel_slot = 0, ready never asserted.
  - Required: ERR entered exactly 4 ACTIVE cycles after SETUP; err_code = 10; err_win = latched index; cs released on ERR entry.
- Timeout vs ready:
  - Stimulus: ready asserted on the final timeout cycle.
  - Required: DONE, no error.
  - Stimulus: clr_err pulsed on the same edge as a new timeout.
  - Required: err_flag remains 1 with code 10.
- Abort and reset:
  - Stimulus: iorq_n rises during ACTIVE.
  - Required: cs high next edge, no error, IDLE.
  - Stimulus: rst_n low during DONE.
  - Required: all outputs return to reset values immediately.

Source files
------------

// File: rtl/dock_io_pkg.sv
// dock_io_pkg: shared state and error-code definitions for the Dock I/O cycle controller.
package dock_io_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, DONE, ERR} state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_UNMAPPED = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/dock_io_cycle.sv
// dock_io_cycle: per-request slot chip-select sequencer with timeout and sticky error status.
module dock_io_cycle
    import dock_io_pkg::*;
#(
    parameter int NUM_SLOTS   = 5,
    parameter int WIN_INDEX_W = 4,
    parameter int SETUP_CYC   = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   iorq_n,
    input  logic                   win_valid,
    input  logic [WIN_INDEX_W-1:0] win_index,
    input  logic [2:0]             sel_slot,
    input  logic                   is_read,
    input  logic [NUM_SLOTS-1:0]   slot_ready_n,
    input  logic                   clr_err,
    output logic [NUM_SLOTS-1:0]   slot_cs_n,
    output logic                   cyc_read,
    output logic                   cpu_ready,
    output logic                   bus_err,
    output logic                   err_flag,
    output logic [1:0]             err_code,
    output logic [WIN_INDEX_W-1:0] err_win
);

    localparam logic [7:0] SETUP_LAST   = 8'(SETUP_CYC > 0 ? SETUP_CYC - 1 : 0);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t                 state, nxt;
    logic [7:0]             cnt;
    logic [2:0]             slot, cs_slot;
    logic [WIN_INDEX_W-1:0] win;
    logic                   mapped, ready, err_entry, rdy_d, berr_d;
    logic [NUM_SLOTS-1:0]   cs_d;

    assign mapped = win_valid && 32'(sel_slot) < NUM_SLOTS;
    assign ready  = |(~slot_ready_n & (NUM_SLOTS'(1) << slot));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            slot      <= 3'd0;
            win       <= '0;
            cyc_read  <= 1'b0;
            slot_cs_n <= '1;
            cpu_ready <= 1'b0;
            bus_err   <= 1'b0;
            err_flag  <= 1'b0;
            err_code  <= ERR_NONE;
            err_win   <= '0;
        end else begin
            state     <= nxt;
            cnt       <= (nxt == state && (state == SETUP || state == ACTIVE)) ? cnt + 8'd1 : 8'd0;
            slot_cs_n <= cs_d;
            cpu_ready <= rdy_d;
            bus_err   <= berr_d;
            if (state == IDLE && !iorq_n) begin
                slot     <= sel_slot;
                win      <= win_index;
                cyc_read <= is_read;
            end
            // a fresh error outranks a coincident clear
            if (err_entry) begin
                err_flag <= 1'b1;
                err_code <= state == IDLE ? ERR_UNMAPPED : ERR_TIMEOUT;
                err_win  <= state == IDLE ? '0 : win;
            end else if (clr_err) begin
                err_flag <= 1'b0;
                err_code <= ERR_NONE;
                err_win  <= '0;
            end
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (!iorq_n) nxt = !mapped ? ERR : (SETUP_CYC == 0 ? ACTIVE : SETUP);
            SETUP:   nxt = iorq_n ? IDLE : (cnt == SETUP_LAST ? ACTIVE : SETUP);
            ACTIVE:  nxt = iorq_n ? IDLE : ready ? DONE : (cnt == TIMEOUT_LAST ? ERR : ACTIVE);
            default: if (iorq_n) nxt = IDLE;
        endcase
    end

    // outputs are computed from the next state so the registers track it exactly
    always_comb begin
        cs_slot   = state == IDLE ? sel_slot : slot;
        cs_d      = (nxt == SETUP || nxt == ACTIVE || nxt == DONE) ? ~(NUM_SLOTS'(1) << cs_slot) : '1;
        rdy_d     = nxt == DONE || nxt == ERR;
        berr_d    = nxt == ERR;
        err_entry = nxt == ERR && state != ERR;
    end

endmodule
